// File: rtl/mult_pkg.sv
// Shared definitions for the 4x4 shift-and-add multiplier controller:
// state encoding and partial-product shift codes.
package mult_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      PP0  = 3'd2,
      PP1  = 3'd3,
      PP2  = 3'd4,
      PP3  = 3'd5,
      DONE = 3'd6
   } state_e;

   // Shift applied to the 2x2 partial product before accumulation
   localparam logic [1:0] SH_0 = 2'b00;
   localparam logic [1:0] SH_2 = 2'b01;
   localparam logic [1:0] SH_4 = 2'b10;

endpackage

// File: rtl/mult_ctrl_decode.sv
// Moore output decoder: turns the controller state into datapath control
// strobes. Purely combinational; unused encodings decode to all-zero.
module mult_ctrl_decode
   import mult_pkg::*;
(
   input  state_e     state_i,
   output logic       busy_o,
   output logic       done_o,
   output logic       ldA_o,
   output logic       ldB_o,
   output logic       l1_o,
   output logic       l2_o,
   output logic [1:0] shctrl_o,
   output logic       ldOut_o,
   output logic       rstOut_o
);

   // Each PP state picks one pair of operand halves and its weight
   always_comb begin
      busy_o   = 1'b0;
      done_o   = 1'b0;
      ldA_o    = 1'b0;
      ldB_o    = 1'b0;
      l1_o     = 1'b0;
      l2_o     = 1'b0;
      shctrl_o = SH_0;
      ldOut_o  = 1'b0;
      rstOut_o = 1'b0;
      case (state_i)
         LOAD: begin
            busy_o   = 1'b1;
            ldA_o    = 1'b1;
            ldB_o    = 1'b1;
            rstOut_o = 1'b1;
         end
         PP0: begin
            busy_o   = 1'b1;
            ldOut_o  = 1'b1;
         end
         PP1: begin
            busy_o   = 1'b1;
            l1_o     = 1'b1;
            shctrl_o = SH_2;
            ldOut_o  = 1'b1;
         end
         PP2: begin
            busy_o   = 1'b1;
            l2_o     = 1'b1;
            shctrl_o = SH_2;
            ldOut_o  = 1'b1;
         end
         PP3: begin
            busy_o   = 1'b1;
            l1_o     = 1'b1;
            l2_o     = 1'b1;
            shctrl_o = SH_4;
            ldOut_o  = 1'b1;
         end
         DONE: done_o = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/mult_controller.sv
// Sequencer for a 4x4 multiplier built from four 2x2 partial products.
// Fixed six-cycle operation: LOAD, PP0..PP3, DONE.
module mult_controller
   import mult_pkg::*;
#(
   parameter bit DONE_HOLD = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic busy,
   output logic done,
   output logic ld_A,
   output logic ld_B,
   output logic l_1,
   output logic l_2,
   output logic shctrl_1,
   output logic shctrl_0,
   output logic ld_out,
   output logic rst_out
);

   state_e     state_q;
   state_e     state_d;
   logic [1:0] shctrl;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // start is only looked at in IDLE and DONE; mid-operation requests are dropped
   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE: state_d = start ? LOAD : IDLE;
         LOAD: state_d = PP0;
         PP0:  state_d = PP1;
         PP1:  state_d = PP2;
         PP2:  state_d = PP3;
         PP3:  state_d = DONE;
         DONE: begin
            if (start)          state_d = LOAD;
            else if (DONE_HOLD) state_d = DONE;
            else                state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   mult_ctrl_decode uDecode (
      .state_i  (state_q),
      .busy_o   (busy),
      .done_o   (done),
      .ldA_o    (ld_A),
      .ldB_o    (ld_B),
      .l1_o     (l_1),
      .l2_o     (l_2),
      .shctrl_o (shctrl),
      .ldOut_o  (ld_out),
      .rstOut_o (rst_out)
   );

   assign shctrl_1 = shctrl[1];
   assign shctrl_0 = shctrl[0];

endmodule
